count_sequencer: RTL and testbench

COUNT_SEQUENCER -- requirements
Module: count_sequencer

---
 rtl/count_sequencer.sv | 151 +++++++++++++++
 tb/tb_count_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// Gate/capture sequencer: settle, open a count window, capture the count, push {chan,count} downstream.
// Latency start->enable SETTLE_CYC+1 edges, fallingedge->fifo_wr_en 2 edges; FIFO full drops the word (sticky overflow).
`timescale 1ns/1ps
module count_sequencer #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic        clk_12mhz,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        alt_en,
  input  logic        chan_sel,
  input  logic [15:0] window_len,
  input  logic        fallingedge,
  input  logic [22:0] count_p,
  input  logic        fifo_full,
  input  logic        clr_flags,
  output logic        count_mode,
  output logic        enable,
  output logic        fifo_wr_en,
  output logic [23:0] fifo_data,
  output logic        busy,
  output logic        overflow,
  output logic        timeout_err
);

  typedef enum logic [2:0] {IDLE, ARM, MEASURE, CAPTURE, STORE, NEXT} state_t;

  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  logic        chan;
  logic        stop_req;
  logic [15:0] cnt;
  logic [23:0] data;
  logic        start_q;
  logic        stop_q;
  logic        fe_q;
  logic [22:0] count_q;
  logic        next_chan;

  assign next_chan = alt_en ? ~chan : chan_sel;

  always_ff @(posedge clk_12mhz or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      chan        <= 1'b0;
      stop_req    <= 1'b0;
      cnt         <= '0;
      data        <= '0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      fe_q        <= 1'b0;
      count_q     <= '0;
      count_mode  <= 1'b0;
      enable      <= 1'b0;
      fifo_wr_en  <= 1'b0;
      fifo_data   <= '0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Inputs pass through one register stage; this stage sets both latencies.
      start_q    <= start;
      stop_q     <= stop;
      fe_q       <= fallingedge && (state == CAPTURE);
      count_q    <= count_p;
      fifo_wr_en <= 1'b0;

      // Clear first so a set later in this block takes priority.
      if (clr_flags) begin
        overflow    <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (state != IDLE && stop_q)
        stop_req <= 1'b1;

      case (state)
        IDLE: begin
          if (start_q && !stop_q) begin
            state      <= ARM;
            chan       <= chan_sel;
            count_mode <= chan_sel;
            stop_req   <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b1;
          end
        end
        ARM: begin
          if (cnt >= SETTLE_LAST) begin
            state  <= MEASURE;
            enable <= 1'b1;
            cnt    <= (window_len == 16'd0) ? 16'd1 : window_len;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        MEASURE: begin
          if (cnt <= 16'd1) begin
            state  <= CAPTURE;
            enable <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        CAPTURE: begin
          if (fe_q) begin
            data  <= {chan, count_q};
            state <= STORE;
          end else if (cnt >= TIMEOUT_LAST) begin
            data        <= {chan, 23'h7FFFFF};
            timeout_err <= 1'b1;
            state       <= STORE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STORE: begin
          if (!fifo_full) begin
            fifo_wr_en <= 1'b1;
            fifo_data  <= data;
          end else begin
            overflow <= 1'b1;
          end
          state <= NEXT;
        end
        NEXT: begin
          if (stop_req || stop_q) begin
            state    <= IDLE;
            busy     <= 1'b0;
            stop_req <= 1'b0;
          end else begin
            chan       <= next_chan;
            count_mode <= next_chan;
            cnt        <= '0;
            state      <= ARM;
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: table of single-shot runs plus hand sequences.
// FIFO words are predicted into a queue when stimulus is driven and compared as writes appear.
`timescale 1ns/1ps
module tb_count_sequencer;
  localparam int SETTLE   = 4;
  localparam int TMO      = 16;
  localparam int WR_BOUND = 20;

  logic        clk_12mhz = 1'b0;
  logic        reset, start, stop, alt_en, chan_sel, fallingedge, fifo_full, clr_flags;
  logic [15:0] window_len;
  logic [22:0] count_p;
  logic        count_mode, enable, fifo_wr_en, busy, overflow, timeout_err;
  logic [23:0] fifo_data;

  int          checks   = 0;
  int          errors   = 0;
  int          wr_count = 0;
  logic        prev_wr  = 1'b0;
  logic [23:0] sb[$];

  typedef struct {
    logic [15:0] wl;
    logic        cs;
    logic [22:0] cnt;
    int          fed;
    logic        full;
    logic [23:0] word;
    int          exp_en;
    int          exp_wr_lat;
    logic        exp_ovf;
  } vec_t;

  always #41 clk_12mhz = ~clk_12mhz;

  count_sequencer #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
    .clk_12mhz(clk_12mhz), .reset(reset), .start(start), .stop(stop),
    .alt_en(alt_en), .chan_sel(chan_sel), .window_len(window_len),
    .fallingedge(fallingedge), .count_p(count_p), .fifo_full(fifo_full),
    .clr_flags(clr_flags), .count_mode(count_mode), .enable(enable),
    .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .busy(busy),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Every wait goes through here so FIFO writes are scored on each cycle.
  task automatic tick();
    logic [23:0] exp_w;
    @(negedge clk_12mhz);
    if (fifo_wr_en) begin
      wr_count++;
      if (prev_wr) begin
        checks++;
        errors++;
        $display("FAIL wr_en_b2b: got two consecutive strobes, required one");
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got fifo_data %h, required no write", fifo_data);
      end else begin
        exp_w = sb.pop_front();
        check("fifo_data", {8'h0, fifo_data}, {8'h0, exp_w});
      end
    end
    prev_wr = fifo_wr_en;
  endtask

  // One measurement with stop raised in MEASURE; fed<0 means no capture pulse.
  task automatic run_one(input logic [15:0] wl, input logic cs, input logic [22:0] cnt,
                         input int fed, input logic full, input logic clr_store,
                         input logic [23:0] word,
                         output int st_lat, output int en_cyc, output int wr_lat,
                         output logic cm);
    int n;
    window_len = wl;
    chan_sel   = cs;
    fifo_full  = full;
    alt_en     = 1'b0;
    start      = 1'b1;
    st_lat     = 0;
    while (!enable && st_lat < 50) begin
      tick();
      st_lat++;
      start = 1'b0;
    end
    cm   = count_mode;
    stop = 1'b1;
    en_cyc = 0;
    while (enable && en_cyc < 1000) begin
      en_cyc++;
      tick();
    end
    if (fed >= 0) begin
      repeat (fed) tick();
      fallingedge = 1'b1;
      count_p     = cnt;
    end
    if (!full) sb.push_back(word);
    wr_lat = 0;
    while (!fifo_wr_en && wr_lat < WR_BOUND) begin
      tick();
      wr_lat++;
      fallingedge = 1'b0;
      clr_flags   = clr_store && (wr_lat == 2);
    end
    clr_flags   = 1'b0;
    fallingedge = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    stop = 1'b0;
    tick();
  endtask

  initial begin
    vec_t        vecs[4];
    int          st_lat, en_cyc, wr_lat, n, w0;
    logic        cm;
    logic [22:0] alt_cnt[3];
    logic        alt_ch[3];

    vecs[0] = '{16'd10, 1'b1, 23'h000123, 3, 1'b0, 24'h800123, 10, 3, 1'b0};
    vecs[1] = '{16'd0,  1'b0, 23'h055AA5, 0, 1'b0, 24'h055AA5, 1,  3, 1'b0};
    vecs[2] = '{16'd3,  1'b1, 23'h7FFFFE, 5, 1'b0, 24'hFFFFFE, 3,  3, 1'b0};
    vecs[3] = '{16'd2,  1'b0, 23'h000001, 1, 1'b1, 24'h000001, 2,  WR_BOUND, 1'b1};
    alt_cnt = '{23'h000011, 23'h000022, 23'h000033};
    alt_ch  = '{1'b0, 1'b1, 1'b0};

    reset = 1'b1; start = 1'b0; stop = 1'b0; alt_en = 1'b0; chan_sel = 1'b0;
    fallingedge = 1'b0; fifo_full = 1'b0; clr_flags = 1'b0;
    window_len = 16'd0; count_p = '0;
    tick(); tick();
    check("rst_outputs", {25'h0, count_mode, enable, fifo_wr_en, busy, overflow, timeout_err},
          32'h0);
    check("rst_fifo_data", {8'h0, fifo_data}, 32'h0);
    reset = 1'b0;
    tick(); tick();
    check("idle_after_reset", {31'h0, busy}, 32'h0);

    for (int i = 0; i < 4; i++) begin
      run_one(vecs[i].wl, vecs[i].cs, vecs[i].cnt, vecs[i].fed, vecs[i].full, 1'b0,
              vecs[i].word, st_lat, en_cyc, wr_lat, cm);
      // negedges counted include the one right after the start-sampling edge
      check($sformatf("v%0d_start_lat", i), st_lat, SETTLE + 2);
      check($sformatf("v%0d_count_mode", i), {31'h0, cm}, {31'h0, vecs[i].cs});
      check($sformatf("v%0d_en_cycles", i), en_cyc, vecs[i].exp_en);
      check($sformatf("v%0d_wr_lat", i), wr_lat, vecs[i].exp_wr_lat);
      check($sformatf("v%0d_overflow", i), {31'h0, overflow}, {31'h0, vecs[i].exp_ovf});
      check($sformatf("v%0d_idle", i), {31'h0, busy}, 32'h0);
      clr_flags = 1'b1; tick(); clr_flags = 1'b0; tick();
      check($sformatf("v%0d_ovf_cleared", i), {31'h0, overflow}, 32'h0);
    end

    // Capture timeout: write lands 17 cycles after CAPTURE entry.
    run_one(16'd2, 1'b0, 23'h0, -1, 1'b0, 1'b0, 24'h7FFFFF, st_lat, en_cyc, wr_lat, cm);
    check("tmo_wr_lat", wr_lat, TMO + 1);
    check("tmo_flag", {31'h0, timeout_err}, 32'h1);
    tick(); tick(); tick();
    check("tmo_sticky", {31'h0, timeout_err}, 32'h1);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0; tick();
    check("tmo_cleared", {31'h0, timeout_err}, 32'h0);

    // Two drops; the second drop coincides with clr_flags and must win.
    run_one(16'd1, 1'b1, 23'h5, 2, 1'b1, 1'b0, 24'h0, st_lat, en_cyc, wr_lat, cm);
    check("drop1_ovf", {31'h0, overflow}, 32'h1);
    run_one(16'd1, 1'b1, 23'h6, 2, 1'b1, 1'b1, 24'h0, st_lat, en_cyc, wr_lat, cm);
    check("drop2_set_wins", {31'h0, overflow}, 32'h1);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0; tick();
    check("drop_cleared", {31'h0, overflow}, 32'h0);
    fifo_full = 1'b0;

    // Alternating channels, start held, stop raised in the third window.
    w0 = wr_count;
    alt_en = 1'b1; chan_sel = 1'b0; window_len = 16'd2; start = 1'b1;
    n = 0;
    for (int m = 0; m < 3; m++) begin
      while (!enable && n < 300) begin tick(); n++; end
      if (m == 2) stop = 1'b1;
      while (enable && n < 300) begin tick(); n++; end
      fallingedge = 1'b1;
      count_p     = alt_cnt[m];
      sb.push_back({alt_ch[m], alt_cnt[m]});
      tick();
      fallingedge = 1'b0;
    end
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    repeat (10) tick();
    check("alt_writes", wr_count - w0, 3);
    check("alt_idle", {31'h0, busy}, 32'h0);
    start = 1'b0; stop = 1'b0; alt_en = 1'b0;
    tick();

    // Reset in CAPTURE with a capture pending: no write may follow.
    w0 = wr_count;
    window_len = 16'd2; chan_sel = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    n = 0;
    while (!enable && n < 50) begin tick(); n++; end
    while (enable && n < 50) begin tick(); n++; end
    fallingedge = 1'b1; count_p = 23'h000777;
    tick();
    fallingedge = 1'b0;
    check("pre_rst_count_mode", {31'h0, count_mode}, 32'h1);
    reset = 1'b1;
    #1;
    check("midrun_rst_outputs",
          {25'h0, count_mode, enable, fifo_wr_en, busy, overflow, timeout_err}, 32'h0);
    check("midrun_rst_fifo_data", {8'h0, fifo_data}, 32'h0);
    tick(); tick();
    reset = 1'b0;
    repeat (20) tick();
    check("midrun_rst_no_write", wr_count - w0, 0);
    check("midrun_rst_idle", {31'h0, busy}, 32'h0);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
